// File: rtl/division_control_unit.sv
// Sequencing front-end for the integer divider: handles signed/unsigned operand
// conditioning, the divide-by-zero and overflow special cases, and result sign fix-up.
module division_control_unit #(
  parameter int unsigned RD_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [31:0]         operand1_i,
  input  logic [31:0]         operand2_i,
  input  logic [RD_WIDTH-1:0] rd_i,
  input  logic                flush_i,
  output logic                div_start_o,
  output logic                div_abort_o,
  output logic [31:0]         div_operand1_o,
  output logic [31:0]         div_operand2_o,
  input  logic                div_done_i,
  input  logic [63:0]         div_result_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         result_o,
  output logic [RD_WIDTH-1:0] rd_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q;
  logic [31:0]         div_op1_q, div_op2_q, result_q;
  logic [RD_WIDTH-1:0] rd_q;
  logic                is_rem_q, neg_q;

  logic        signed_op, is_rem, div_by_zero, overflow, special, neg;
  logic [31:0] special_res, abs1, abs2, raw_res, fixed_res;

  // Opcode bit 0 selects unsigned, bit 1 selects remainder.
  always_comb begin
    signed_op   = ~op_i[0];
    is_rem      = op_i[1];
    div_by_zero = (operand2_i == 32'h0);
    overflow    = signed_op && (operand1_i == 32'h8000_0000) && (operand2_i == 32'hFFFF_FFFF);
    special     = div_by_zero || overflow;
    special_res = 32'h0;
    if (div_by_zero) begin
      special_res = is_rem ? operand1_i : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_res = is_rem ? 32'h0 : 32'h8000_0000;
    end
    // Two's-complement negation leaves 0x80000000 unchanged, which is its unsigned magnitude.
    abs1 = (signed_op && operand1_i[31]) ? (~operand1_i + 32'd1) : operand1_i;
    abs2 = (signed_op && operand2_i[31]) ? (~operand2_i + 32'd1) : operand2_i;
    neg  = signed_op && (is_rem ? operand1_i[31] : (operand1_i[31] ^ operand2_i[31]));
  end

  always_comb begin
    raw_res   = is_rem_q ? div_result_i[63:32] : div_result_i[31:0];
    fixed_res = neg_q ? (~raw_res + 32'd1) : raw_res;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      div_op1_q <= 32'h0;
      div_op2_q <= 32'h0;
      result_q  <= 32'h0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      neg_q     <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            rd_q     <= rd_i;
            is_rem_q <= is_rem;
            neg_q    <= neg;
            if (special) begin
              result_q <= special_res;
              state_q  <= StDone;
            end else begin
              div_op1_q <= abs1;
              div_op2_q <= abs2;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (div_done_i) begin
            result_q <= fixed_res;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready_o     = (state_q == StIdle) && !flush_i;
    div_start_o    = (state_q == StIssue) && !flush_i;
    div_abort_o    = flush_i && ((state_q == StIssue) || (state_q == StWait));
    out_valid_o    = (state_q == StDone);
    busy_o         = (state_q != StIdle);
    div_operand1_o = div_op1_q;
    div_operand2_o = div_op2_q;
    result_o       = result_q;
    rd_o           = rd_q;
  end

endmodule

// File: tb/tb_division_control_unit.sv
// Directed bench for division_control_unit: inputs driven 1ns after the rising edge,
// outputs sampled on the falling edge; the divider is played by hand-written responses.
module tb_division_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i, in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] operand1_i, operand2_i;
  logic [4:0]  rd_i, rd_o;
  logic        flush_i, div_start_o, div_abort_o;
  logic [31:0] div_operand1_o, div_operand2_o, result_o;
  logic        div_done_i, out_valid_o, out_ready_i, busy_o;
  logic [63:0] div_result_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  always #5 clk_i = ~clk_i;

  division_control_unit #(.RD_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .operand1_i(operand1_i), .operand2_i(operand2_i), .rd_i(rd_i),
    .flush_i(flush_i), .div_start_o(div_start_o), .div_abort_o(div_abort_o),
    .div_operand1_o(div_operand1_o), .div_operand2_o(div_operand2_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    in_valid_i = 1'b1;
    op_i       = op;
    operand1_i = a;
    operand2_i = b;
    rd_i       = rd;
  endtask

  task automatic run_normal(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] q,
                            input logic [31:0] r, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] eres);
    cyc(); drive_op(op, a, b, rd);
    mid(); check_eq({tag, ".in_ready"}, in_ready_o, 1);
    cyc(); in_valid_i = 1'b0;
    mid(); check_eq({tag, ".start"}, div_start_o, 1);
    check_eq({tag, ".opnd1"}, div_operand1_o, e1);
    check_eq({tag, ".opnd2"}, div_operand2_o, e2);
    cyc();
    mid(); check_eq({tag, ".start_gone"}, div_start_o, 0);
    check_eq({tag, ".opnd1_hold"}, div_operand1_o, e1);
    cyc(); div_done_i = 1'b1; div_result_i = {r, q};
    mid(); check_eq({tag, ".no_valid_at_D"}, out_valid_o, 0);
    cyc(); div_done_i = 1'b0; div_result_i = 64'h0; out_ready_i = 1'b1;
    mid(); check_eq({tag, ".valid"}, out_valid_o, 1);
    check_eq({tag, ".result"}, result_o, eres);
    check_eq({tag, ".rd"}, rd_o, rd);
    check_eq({tag, ".ready_low"}, in_ready_o, 0);
    cyc(); out_ready_i = 1'b0;
    mid(); check_eq({tag, ".idle"}, {busy_o, out_valid_o, in_ready_o}, 3'b001);
  endtask

  task automatic run_special(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] eres);
    cyc(); drive_op(op, a, b, rd);
    mid(); check_eq({tag, ".in_ready"}, in_ready_o, 1);
    cyc(); in_valid_i = 1'b0; out_ready_i = 1'b1;
    mid(); check_eq({tag, ".valid_T1"}, out_valid_o, 1);
    check_eq({tag, ".result"}, result_o, eres);
    check_eq({tag, ".rd"}, rd_o, rd);
    check_eq({tag, ".no_start"}, div_start_o, 0);
    cyc(); out_ready_i = 1'b0;
    mid(); check_eq({tag, ".idle"}, {busy_o, out_valid_o, in_ready_o}, 3'b001);
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; op_i = 2'b00; operand1_i = 32'h0; operand2_i = 32'h0;
    rd_i = 5'h0; flush_i = 1'b0; div_done_i = 1'b0; div_result_i = 64'h0; out_ready_i = 1'b0;
    #2;
    check_eq("reset.outs", {out_valid_o, div_start_o, div_abort_o, busy_o}, 4'b0000);
    check_eq("reset.data", {result_o, div_operand1_o, div_operand2_o, 27'h0, rd_o}, 128'h0);
    cyc(); cyc(); rst_ni = 1'b1;
    mid(); check_eq("reset.ready_after", in_ready_o, 1);

    run_normal("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'h2, 5'd3, 32'd3, 32'd1,
               32'd7, 32'd2, 32'hFFFF_FFFD);
    run_normal("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'h2, 5'd4, 32'd3, 32'd1,
               32'd7, 32'd2, 32'hFFFF_FFFF);
    run_normal("remu_big", OpRemu, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'h7FFF_FFFC, 32'd1,
               32'hFFFF_FFF9, 32'h2, 32'd1);
    run_normal("divu_100_7", OpDivu, 32'd100, 32'd7, 5'd31, 32'd14, 32'd2,
               32'd100, 32'd7, 32'd14);
    run_normal("div_20_m3", OpDiv, 32'd20, 32'hFFFF_FFFD, 5'd6, 32'd6, 32'd2,
               32'd20, 32'd3, 32'hFFFF_FFFA);
    run_normal("rem_20_m3", OpRem, 32'd20, 32'hFFFF_FFFD, 5'd7, 32'd6, 32'd2,
               32'd20, 32'd3, 32'd2);
    run_normal("div_min_2", OpDiv, 32'h8000_0000, 32'h2, 5'd8, 32'h4000_0000, 32'd0,
               32'h8000_0000, 32'h2, 32'hC000_0000);
    run_normal("divu_min_m1", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0,
               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    run_special("divu_5_0", OpDivu, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    run_special("rem_5_0", OpRem, 32'd5, 32'd0, 5'd11, 32'd5);
    run_special("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run_special("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    run_special("div_m7_0", OpDiv, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF);
    run_special("remu_9_0", OpRemu, 32'd9, 32'd0, 5'd15, 32'd9);

    // Flush while waiting on the divider; the late done must be ignored.
    cyc(); drive_op(OpDiv, 32'd100, 32'd7, 5'd1);
    cyc(); in_valid_i = 1'b0;
    mid(); check_eq("fl_wait.start", div_start_o, 1);
    cyc();
    cyc(); flush_i = 1'b1;
    mid(); check_eq("fl_wait.abort", div_abort_o, 1);
    cyc(); flush_i = 1'b0; div_done_i = 1'b1; div_result_i = {32'd2, 32'd14};
    mid(); check_eq("fl_wait.after", {div_abort_o, busy_o, out_valid_o, in_ready_o}, 4'b0001);
    cyc(); div_done_i = 1'b0; div_result_i = 64'h0;
    mid(); check_eq("fl_wait.late_done", {busy_o, out_valid_o}, 2'b00);

    // Flush in ISSUE suppresses the start pulse.
    cyc(); drive_op(OpDivu, 32'd50, 32'd5, 5'd2);
    cyc(); in_valid_i = 1'b0; flush_i = 1'b1;
    mid(); check_eq("fl_issue.start_abort", {div_start_o, div_abort_o}, 2'b01);
    cyc(); flush_i = 1'b0;
    mid(); check_eq("fl_issue.after", {div_start_o, div_abort_o, busy_o}, 3'b000);

    // Flush beats a same-cycle accept.
    cyc(); drive_op(OpDiv, 32'd9, 32'd3, 5'd3); flush_i = 1'b1;
    mid(); check_eq("fl_acc.ready", {in_ready_o, div_abort_o}, 2'b00);
    cyc(); in_valid_i = 1'b0; flush_i = 1'b0;
    mid(); check_eq("fl_acc.after", {busy_o, div_start_o, out_valid_o}, 3'b000);

    // Flush beats a same-cycle result transfer.
    cyc(); drive_op(OpDivu, 32'd5, 32'd0, 5'd4);
    cyc(); in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b1;
    mid(); check_eq("fl_done.valid", out_valid_o, 1);
    cyc(); out_ready_i = 1'b0; flush_i = 1'b0;
    mid(); check_eq("fl_done.after", {busy_o, out_valid_o, in_ready_o}, 3'b001);

    // Backpressure: result held, no new accept while waiting on writeback.
    cyc(); drive_op(OpDivu, 32'd5, 32'd0, 5'd9);
    cyc(); drive_op(OpDivu, 32'd1, 32'd1, 5'd20);
    for (int i = 0; i < 5; i++) begin
      mid(); check_eq("hold.state", {out_valid_o, in_ready_o, div_start_o}, 3'b100);
      check_eq("hold.data", {result_o, 27'h0, rd_o}, {32'hFFFF_FFFF, 32'd9});
      cyc();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    mid(); check_eq("hold.xfer", out_valid_o, 1);
    cyc(); out_ready_i = 1'b0;
    mid(); check_eq("hold.after", {busy_o, out_valid_o, in_ready_o}, 3'b001);

    // Asynchronous reset in WAIT.
    cyc(); drive_op(OpDiv, 32'hFFFF_FFF9, 32'h2, 5'd17);
    cyc(); in_valid_i = 1'b0;
    cyc();
    mid(); check_eq("rst_mid.busy_before", busy_o, 1);
    #2; rst_ni = 1'b0;
    #1;
    check_eq("rst_mid.outs", {out_valid_o, div_start_o, div_abort_o, busy_o}, 4'b0000);
    check_eq("rst_mid.data", {result_o, div_operand1_o, div_operand2_o, 27'h0, rd_o}, 128'h0);
    cyc(); rst_ni = 1'b1; div_done_i = 1'b1; div_result_i = {32'd1, 32'd3};
    mid(); check_eq("rst_mid.after", {in_ready_o, busy_o, out_valid_o, div_start_o}, 4'b1000);
    cyc(); div_done_i = 1'b0; div_result_i = 64'h0;
    mid(); check_eq("rst_mid.quiet", {busy_o, out_valid_o, div_start_o, div_abort_o}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/division_control_unit.md
DIVISION_CONTROL_UNIT -- requirements
Module: division_control_unit

Interface
REQ-001 SHALL have parameter RD_WIDTH, default 5: width of the destination-register tag carried with each operation.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i, input, 1: decode presents a division op.
REQ-005 SHALL have port in_ready_o, output, 1: block can accept an op.
REQ-006 SHALL have port op_i, input, 2: op select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port operand1_i and operand2_i, input, 32 each: dividend and divisor.
REQ-008 SHALL have port rd_i, input, RD_WIDTH: destination tag.
REQ-009 SHALL have port flush_i, input, 1: pipeline flush.
REQ-010 SHALL have port div_start_o, output, 1: one-cycle start pulse to the integer division unit.
REQ-011 SHALL have port div_abort_o, output, 1: one-cycle abort pulse to the integer division unit.
REQ-012 SHALL have port div_operand1_o and div_operand2_o, output, 32 each: unsigned magnitudes sent to the divider.
REQ-013 SHALL have port div_done_i, input, 1: divider result valid.
REQ-014 SHALL have port div_result_i, input, 64: divider output. [31:0] is the unsigned quotient; [63:32] is the unsigned remainder.
REQ-015 SHALL have port out_valid_o, output, 1: result available for writeback.
REQ-016 SHALL have port out_ready_i, input, 1: writeback accepts the result.
REQ-017 SHALL have port result_o, output, 32: final result.
REQ-018 SHALL have port rd_o, output, RD_WIDTH: tag of the result.
REQ-019 SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-021 SHALL drive in_ready_o high only in IDLE with flush_i low.
REQ-022 SHALL accept an op when in_valid_i and in_ready_o are both high, latching op_i, both operands and rd_i.
REQ-023 SHALL go from IDLE to DONE on accept when the op is a special case, with the result computed without using the divider.
 - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
 - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-024 SHALL go from IDLE to ISSUE on accept of any other op.
REQ-025 SHALL, in ISSUE, assert div_start_o for exactly one cycle and drive the divider operands, then go to WAIT.
 - Signed ops: each operand is converted to its absolute value; 0x80000000 stays 0x80000000 as unsigned.
 - Unsigned ops: operands are passed unchanged.
REQ-026 SHALL hold div_operand1_o and div_operand2_o stable from ISSUE until WAIT exits.
REQ-027 SHALL, in WAIT on div_done_i, register the sign-corrected result and go to DONE.
 - DIV: quotient negated when the operand signs differ.
 - REM: remainder negated when the dividend is negative.
 - DIVU and REMU: raw quotient or remainder.
REQ-028 SHALL ignore div_done_i in every state except WAIT.
REQ-029 SHALL, in DONE, assert out_valid_o with result_o and rd_o held stable until out_ready_i is high, then return to IDLE.
REQ-030 SHALL NOT accept a new op in the cycle the result transfers; a new op is accepted no earlier than the following cycle.
REQ-031 SHALL return to IDLE on the next edge when flush_i is high, from any state, with out_valid_o low from that edge on.
REQ-032 SHALL give flush_i priority over a same-cycle accept or result transfer; that op or result is discarded.
REQ-033 SHALL pulse div_abort_o for one cycle when flush_i is high in ISSUE or WAIT.
REQ-034 SHALL NOT assert div_start_o in a cycle where flush_i is high.
REQ-035 SHALL meet these latencies for an op accepted at cycle T:
 - Special case: out_valid_o high at T+1.
 - Normal op: div_start_o high at T+1; with div_done_i at cycle D, out_valid_o high at D+1.

Reset
REQ-036 SHALL, while rst_ni is low, force the FSM to IDLE.
REQ-037 SHALL, while rst_ni is low, drive these outputs low or zero:
 - out_valid_o, div_start_o, div_abort_o and busy_o.
 - result_o, rd_o, div_operand1_o and div_operand2_o.
REQ-038 SHALL discard any in-flight op when reset is asserted mid-operation, with no output pulse after reset is released.
REQ-039 SHALL drive in_ready_o high in the first cycle after rst_ni rises.

Verification
REQ-040 SHALL pass: DIV -7 / 2 (0xFFFFFFF9, 0x2) with the divider returning {1, 3} -> div operands 7 and 2, result_o 0xFFFFFFFD.
REQ-041 SHALL pass: REM -7 / 2 with the divider returning {1, 3} -> result_o 0xFFFFFFFF; REMU 0xFFFFFFF9 / 2 -> operands passed unchanged.
REQ-042 SHALL pass: DIVU 5 / 0 -> no div_start_o, out_valid_o at T+1, result_o 0xFFFFFFFF; REM 5 / 0 -> result_o 5.
REQ-043 SHALL pass: DIV 0x80000000 / 0xFFFFFFFF -> result_o 0x80000000 at T+1; REM of the same operands -> result_o 0.
REQ-044 SHALL pass: flush_i high in WAIT -> div_abort_o for one cycle, IDLE next, a late div_done_i ignored, no out_valid_o.
REQ-045 SHALL pass: out_ready_i held low for 5 cycles in DONE -> result_o and rd_o stable and in_ready_o low throughout; rst_ni low mid-WAIT -> all outputs zero immediately.
